// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters, with a registered, ID-tagged result.
// Define ADD_SAT_EN to saturate res_sum to all-ones on carry-out; otherwise the sum wraps.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_carry,
    output logic [ID_W-1:0]          res_id,
    output logic [15:0]              grant_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   last_grant_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carry_reg;
    logic [ID_W-1:0]   id_reg;
    logic [15:0]       cnt_reg;

    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              can_accept;
    logic              accept;
    int                idx;

    logic [WIDTH-1:0]  op_a [NUM_REQ];
    logic [WIDTH-1:0]  op_b [NUM_REQ];
    logic [WIDTH:0]    sum_full;
    logic [WIDTH-1:0]  sum_load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts one past the last winner and wraps; depends only on req_valid.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        res_valid  = (state_reg == FULL);
        can_accept = (state_reg == EMPTY) | res_ready;
        accept     = found & can_accept;
        req_ready  = '0;
        if (accept) req_ready[winner] = 1'b1;
        case (state_reg)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (!accept && res_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign sum_full = {1'b0, op_a[winner]} + {1'b0, op_b[winner]};

`ifdef ADD_SAT_EN
    assign sum_load = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign sum_load = sum_full[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            sum_reg        <= '0;
            carry_reg      <= 1'b0;
            id_reg         <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sum_reg        <= sum_load;
                carry_reg      <= sum_full[WIDTH];
                id_reg         <= winner;
                last_grant_reg <= winner;
                cnt_reg        <= cnt_reg + 16'd1;
            end
        end
    end

    assign res_sum   = sum_reg;
    assign res_carry = carry_reg;
    assign res_id    = id_reg;
    assign grant_cnt = cnt_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: expected results queued on each accept, checked while res_valid is high.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_sum;
    logic        res_carry;
    logic [1:0]  res_id;
    logic [15:0] grant_cnt;

    typedef struct {
        logic [1:0] id;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = '0;

    adder_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
        .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    // Called at a negedge with inputs already driven; exp_ready is the grant the bench expects this cycle.
    task automatic step(input logic [3:0] exp_ready, input string name);
        exp_t        e;
        logic [8:0]  s9;
        logic [7:0]  a, b;
        int          g;
        #1;
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("FAIL %s req_ready got=%b exp=%b", name, req_ready, exp_ready);
        end
        total++;
        if (grant_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL %s grant_cnt got=%0d exp=%0d", name, grant_cnt, exp_cnt);
        end
        total++;
        if (res_valid !== (sb.size() != 0)) begin
            bad++;
            $display("FAIL %s res_valid got=%b exp=%b", name, res_valid, sb.size() != 0);
        end
        if (sb.size() != 0) begin
            e = sb[0];
            total++;
            if (res_sum !== e.sum || res_carry !== e.carry || res_id !== e.id) begin
                bad++;
                $display("FAIL %s result got sum=%h c=%b id=%0d exp sum=%h c=%b id=%0d",
                         name, res_sum, res_carry, res_id, e.sum, e.carry, e.id);
            end
            if (res_ready) void'(sb.pop_front());
        end
        if (exp_ready != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
            a  = req_a[g*8 +: 8];
            b  = req_b[g*8 +: 8];
            s9 = {1'b0, a} + {1'b0, b};
            e.id    = 2'(g);
            e.carry = s9[8];
`ifdef ADD_SAT_EN
            e.sum   = s9[8] ? 8'hFF : s9[7:0];
`else
            e.sum   = s9[7:0];
`endif
            sb.push_back(e);
            exp_cnt = exp_cnt + 16'd1;
        end
        $display("cycle %s valid=%b ready=%b res_valid=%b sum=%h c=%b id=%0d cnt=%0d",
                 name, req_valid, req_ready, res_valid, res_sum, res_carry, res_id, grant_cnt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        #2;
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (res_valid !== 1'b0 || res_sum !== 8'h00 || res_carry !== 1'b0 ||
            res_id !== 2'd0 || grant_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset got valid=%b sum=%h c=%b id=%0d cnt=%0d exp all zero",
                     res_valid, res_sum, res_carry, res_id, grant_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req_a[2*8 +: 8] = 8'h12;
        req_b[2*8 +: 8] = 8'h34;
        req_valid = 4'b0100;
        step(4'b0100, "single");
        req_valid = 4'b0000;
        total++;
        if (res_sum !== 8'h46 || res_id !== 2'd2) begin
            bad++;
            $display("FAIL single_value got sum=%h id=%0d exp sum=46 id=2", res_sum, res_id);
        end
        step(4'b0000, "single_drain");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            req_a = $urandom;
            req_b = $urandom;
            step(4'(1 << (i % 4)), "rr");
        end
        req_valid = 4'b0000;
        step(4'b0000, "rr_drain");
        step(4'b0000, "rr_idle");
    endtask

    task automatic test_carry();
        apply_reset();
        req_a[1*8 +: 8] = 8'hF0;
        req_b[1*8 +: 8] = 8'h20;
        req_valid = 4'b0010;
        step(4'b0010, "carry");
        req_valid = 4'b0000;
        total++;
`ifdef ADD_SAT_EN
        if (res_sum !== 8'hFF || res_carry !== 1'b1) begin
            bad++;
            $display("FAIL carry_value got sum=%h c=%b exp sum=ff c=1", res_sum, res_carry);
        end
`else
        if (res_sum !== 8'h10 || res_carry !== 1'b1) begin
            bad++;
            $display("FAIL carry_value got sum=%h c=%b exp sum=10 c=1", res_sum, res_carry);
        end
`endif
        step(4'b0000, "carry_drain");
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b1000;
        step(4'b1000, "bp_fill");
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b1001;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(4'b0000, "bp_hold");
        res_ready = 1'b1;
        step(4'b0001, "bp_release");
        req_valid = 4'b0000;
        step(4'b0000, "bp_drain");
        step(4'b0000, "bp_idle");
    endtask

    task automatic test_idle_priority();
        apply_reset();
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b1000;
        step(4'b1000, "idle_g3");
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) step(4'b0000, "idle");
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b0011;
        step(4'b0001, "idle_g0");
        req_valid = 4'b0000;
        step(4'b0000, "idle_drain");
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b0100;
        step(4'b0100, "ar_fill");
        req_valid = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b0 || grant_cnt !== 16'd0) begin
            bad++;
            $display("FAIL async_reset got valid=%b cnt=%0d exp valid=0 cnt=0", res_valid, grant_cnt);
        end
        #1;
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b1111;
        step(4'b0001, "ar_first");
        req_valid = 4'b0000;
        step(4'b0000, "ar_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_carry();
        test_backpressure();
        test_idle_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
